// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-cache request, miss tolerance, branch redirect and HLT stop.
// Optional FETCH_PERF_CNT_EN adds saturating delivered-instruction and stall-cycle counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_en,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] pc_add_out,
  output logic [15:0] instr_out,
  output logic        fetch_stall,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_instr_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] dlv_pc_s;
  logic        dlv_halt_s;
  logic        deliver_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      pend_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Next PC when an instruction is actually delivered: redirect > stall > HLT > sequential.
  always_comb begin
    dlv_pc_s   = pc_q + 16'd2;
    dlv_halt_s = 1'b0;
    if (redirect_en) begin
      dlv_pc_s = redirect_pc;
    end else if (stall_en) begin
      dlv_pc_s = pc_q;
    end else if (imem_rdata[15:12] == HALT_OPCODE) begin
      dlv_pc_s   = pc_q;
      dlv_halt_s = 1'b1;
    end else begin
      dlv_pc_s = pc_q + 16'd2;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    pend_pc_d    = pend_pc_q;
    case (state_q)
      ST_RUN: begin
        if (imem_valid) begin
          pc_d    = dlv_pc_s;
          state_d = dlv_halt_s ? ST_HALT : ST_RUN;
        end else begin
          // Miss address must stay stable until its fill, so a redirect is parked.
          state_d = ST_MISS;
          if (redirect_en) begin
            redir_pend_d = 1'b1;
            pend_pc_d    = redirect_pc;
          end else begin
            redir_pend_d = redir_pend_q;
          end
        end
      end
      ST_MISS: begin
        if (imem_valid && redir_pend_q) begin
          pc_d         = redirect_en ? redirect_pc : pend_pc_q;
          redir_pend_d = 1'b0;
          state_d      = ST_RUN;
        end else if (imem_valid) begin
          pc_d    = dlv_pc_s;
          state_d = dlv_halt_s ? ST_HALT : ST_RUN;
        end else if (redirect_en) begin
          redir_pend_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_HALT: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_comb begin
    deliver_s   = 1'b0;
    imem_req    = 1'b1;
    halted      = 1'b0;
    case (state_q)
      ST_RUN:  deliver_s = imem_valid;
      ST_MISS: deliver_s = imem_valid && !redir_pend_q;
      ST_HALT: begin
        imem_req = 1'b0;
        halted   = 1'b1;
      end
      default: deliver_s = 1'b0;
    endcase
    imem_addr   = pc_q;
    pc_add_out  = pc_q + 16'd2;
    fetch_stall = !deliver_s;
    instr_out   = deliver_s ? imem_rdata : NOP_INSTR;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_q, perf_stall_q;

  // Saturating counters; HALT cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_instr_q <= 16'h0000;
      perf_stall_q <= 16'h0000;
    end else begin
      if (deliver_s && !stall_en && (perf_instr_q != 16'hFFFF)) begin
        perf_instr_q <= perf_instr_q + 16'd1;
      end
      if (!deliver_s && (state_q != ST_HALT) && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default build; perf ports connected when enabled).
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_en;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] pc_add_out;
  logic [15:0] instr_out;
  logic        fetch_stall;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_en(stall_en), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc_add_out(pc_add_out),
    .instr_out(instr_out), .fetch_stall(fetch_stall), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_en = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
    imem_valid = 1'b1; imem_rdata = 16'h1234;
    cyc(); cyc();
    rst_n = 1'b1; #1;
    tests_run++;
    if (imem_addr !== 16'h0000 || imem_req !== 1'b1 || halted !== 1'b0) begin
      $display("FAIL reset: addr=%h req=%b halted=%b, want 0000 1 0", imem_addr, imem_req, halted);
      tests_failed++;
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] ea;
      ea = 16'(2 * i);
      tests_run++;
      if (imem_addr !== ea || pc_add_out !== ea + 16'd2 || fetch_stall !== 1'b0 || instr_out !== 16'h1234) begin
        $display("FAIL seq%0d: addr=%h pc_add=%h stall=%b instr=%h, want %h %h 0 1234",
                 i, imem_addr, pc_add_out, fetch_stall, instr_out, ea, ea + 16'd2);
        tests_failed++;
      end
      cyc();
    end
  endtask

  task automatic test_miss();
    redirect_en = 1'b1; redirect_pc = 16'h0010;
    cyc();
    redirect_en = 1'b0; imem_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (fetch_stall !== 1'b1 || imem_addr !== 16'h0010 || instr_out !== 16'h0000 || imem_req !== 1'b1) begin
        $display("FAIL miss_wait%0d: stall=%b addr=%h instr=%h req=%b, want 1 0010 0000 1",
                 i, fetch_stall, imem_addr, instr_out, imem_req);
        tests_failed++;
      end
      cyc();
    end
    imem_valid = 1'b1; imem_rdata = 16'hA5A5; #1;
    tests_run++;
    if (fetch_stall !== 1'b0 || instr_out !== 16'hA5A5) begin
      $display("FAIL miss_fill: stall=%b instr=%h, want 0 a5a5", fetch_stall, instr_out);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (imem_addr !== 16'h0012) begin
      $display("FAIL miss_next: addr=%h, want 0012", imem_addr);
      tests_failed++;
    end
  endtask

  task automatic test_miss_redirect();
    imem_valid = 1'b0; #1;
    cyc();
    redirect_en = 1'b1; redirect_pc = 16'h0100;
    cyc();
    redirect_en = 1'b0; #1;
    tests_run++;
    if (imem_addr !== 16'h0012 || fetch_stall !== 1'b1) begin
      $display("FAIL mredir_hold: addr=%h stall=%b, want 0012 1", imem_addr, fetch_stall);
      tests_failed++;
    end
    cyc();
    imem_valid = 1'b1; imem_rdata = 16'hBEEF; #1;
    tests_run++;
    if (fetch_stall !== 1'b1 || instr_out !== 16'h0000 || imem_addr !== 16'h0012) begin
      $display("FAIL mredir_discard: stall=%b instr=%h addr=%h, want 1 0000 0012", fetch_stall, instr_out, imem_addr);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (imem_addr !== 16'h0100 || fetch_stall !== 1'b0 || instr_out !== 16'hBEEF) begin
      $display("FAIL mredir_target: addr=%h stall=%b instr=%h, want 0100 0 beef", imem_addr, fetch_stall, instr_out);
      tests_failed++;
    end
  endtask

  task automatic test_halt();
    imem_rdata = 16'h1234; redirect_en = 1'b1; redirect_pc = 16'h0020;
    cyc();
    redirect_en = 1'b0; imem_rdata = 16'hF000; #1;
    tests_run++;
    if (imem_addr !== 16'h0020 || instr_out !== 16'hF000 || fetch_stall !== 1'b0 || halted !== 1'b0) begin
      $display("FAIL hlt_fetch: addr=%h instr=%h stall=%b halted=%b, want 0020 f000 0 0", imem_addr, instr_out, fetch_stall, halted);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || fetch_stall !== 1'b1 || instr_out !== 16'h0000) begin
      $display("FAIL hlt_state: halted=%b req=%b stall=%b instr=%h, want 1 0 1 0000", halted, imem_req, fetch_stall, instr_out);
      tests_failed++;
    end
    stall_en = 1'b1;
    cyc();
    stall_en = 1'b0; #1;
    tests_run++;
    if (halted !== 1'b1 || imem_addr !== 16'h0020) begin
      $display("FAIL hlt_stall: halted=%b addr=%h, want 1 0020", halted, imem_addr);
      tests_failed++;
    end
    imem_rdata = 16'h1234; redirect_en = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect_en = 1'b0; #1;
    tests_run++;
    if (halted !== 1'b0 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
      $display("FAIL hlt_exit: halted=%b addr=%h req=%b, want 0 0040 1", halted, imem_addr, imem_req);
      tests_failed++;
    end
  endtask

  task automatic test_wrap_and_stall();
    redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    cyc();
    redirect_en = 1'b0; #1;
    tests_run++;
    if (imem_addr !== 16'hFFFE || pc_add_out !== 16'h0000) begin
      $display("FAIL wrap_add: addr=%h pc_add=%h, want fffe 0000", imem_addr, pc_add_out);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (imem_addr !== 16'h0000) begin
      $display("FAIL wrap_next: addr=%h, want 0000", imem_addr);
      tests_failed++;
    end
    stall_en = 1'b1;
    cyc();
    tests_run++;
    if (imem_addr !== 16'h0000 || instr_out !== 16'h1234 || fetch_stall !== 1'b0) begin
      $display("FAIL stall_hold: addr=%h instr=%h stall=%b, want 0000 1234 0", imem_addr, instr_out, fetch_stall);
      tests_failed++;
    end
    redirect_en = 1'b1; redirect_pc = 16'h0200;
    cyc();
    redirect_en = 1'b0; stall_en = 1'b0; #1;
    tests_run++;
    if (imem_addr !== 16'h0200) begin
      $display("FAIL stall_redirect: addr=%h, want 0200", imem_addr);
      tests_failed++;
    end
  endtask

  task automatic test_reset_in_miss();
    imem_valid = 1'b0;
    cyc();
    redirect_en = 1'b1; redirect_pc = 16'h0300;
    cyc();
    redirect_en = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; #1;
    tests_run++;
    if (imem_addr !== 16'h0000 || fetch_stall !== 1'b1 || imem_req !== 1'b1) begin
      $display("FAIL rst_miss_addr: addr=%h stall=%b req=%b, want 0000 1 1", imem_addr, fetch_stall, imem_req);
      tests_failed++;
    end
    cyc();
    imem_valid = 1'b1; imem_rdata = 16'h4321; #1;
    tests_run++;
    if (fetch_stall !== 1'b0 || instr_out !== 16'h4321 || imem_addr !== 16'h0000) begin
      $display("FAIL rst_miss_pend: stall=%b instr=%h addr=%h, want 0 4321 0000", fetch_stall, instr_out, imem_addr);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (imem_addr !== 16'h0002) begin
      $display("FAIL rst_miss_next: addr=%h, want 0002", imem_addr);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_miss_redirect();
    test_halt();
    test_wrap_and_stall();
    test_reset_in_miss();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit pipelined core. Owns the PC register, drives the instruction-memory/I-cache request, and tolerates multi-cycle misses. Handles branch redirects from decode and HLT detection. Produces PC+2 and the fetched instruction for the fetch/decode pipeline register; fetch_stall tells the hazard logic when no valid instruction is presented.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OPCODE, 4'hF, instr[15:12] value that halts fetch
NOP_INSTR, 16'h0000, instruction presented when no valid fetch

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
stall_en  input  1  hazard-unit stall; hold PC
redirect_en  input  1  taken branch resolved in decode
redirect_pc  input  16  branch target
imem_req  output  1  fetch request to I-cache
imem_addr  output  16  fetch address
imem_rdata  input  16  instruction data
imem_valid  input  1  imem_rdata valid for the current request (hit same cycle, or fill after miss)
pc_add_out  output  16  PC+2 of the presented instruction
instr_out  output  16  presented instruction (NOP_INSTR when invalid)
fetch_stall  output  1  1 = instr_out not valid this cycle
halted  output  1  fetch halted on HLT

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n). All state is sampled on the rising edge.
- Reset: pc=RESET_PC, state=RUN, redir_pend=0, pend_pc=0, halted=0. Reset overrides everything, including mid-miss: any in-flight fill is abandoned.
- Outputs are combinational from state, pc and imem inputs. imem_addr=pc in RUN and MISS.
- pc_add_out = pc+2, 16-bit, wraps (16'hFFFE -> 16'h0000).
- RUN:
  - imem_req=1.
  - If imem_valid: instr_out=imem_rdata, fetch_stall=0.
  - Next pc, in priority order: redirect_en -> redirect_pc; stall_en -> pc; instr[15:12]==HALT_OPCODE -> pc, then go to HALT; else pc+2.
  - If !imem_valid: fetch_stall=1, instr_out=NOP_INSTR, go to MISS with pc held. If redirect_en is also set, latch redir_pend=1 and pend_pc=redirect_pc, because the miss address must stay stable until its fill.
- MISS:
  - imem_req=1, imem_addr=pc held, fetch_stall=1.
  - redirect_en here sets redir_pend=1 and pend_pc=redirect_pc; a later redirect overwrites pend_pc.
  - On imem_valid with redir_pend=1: discard data, fetch_stall stays 1, pc=pend_pc, clear redir_pend, go to RUN.
  - On imem_valid with redir_pend=0: deliver the instruction exactly as in RUN, including the same next-pc priority and the HALT check, then go to RUN (or HALT).
- HALT:
  - imem_req=0, fetch_stall=1, instr_out=NOP_INSTR, halted=1.
  - redirect_en (HLT was in a taken-branch shadow): pc=redirect_pc, halted=0, go to RUN.
  - stall_en has no effect.
- Latency: a hit delivers in the same cycle as the request. A miss delivers in the cycle imem_valid rises.
- Simultaneous redirect_en and stall_en: redirect wins, PC updates.
- stall_en with a valid fetch: outputs keep presenting the same instruction; the pipeline register ignores it while stalled.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_instr_cnt[15:0] and perf_stall_cnt[15:0], both synchronously reset to 0 and saturating at 16'hFFFF.
  - perf_instr_cnt increments on each delivered instruction (fetch_stall=0 and stall_en=0).
  - perf_stall_cnt increments each cycle with fetch_stall=1 outside HALT.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then imem_valid=1 always, imem_rdata=16'h1234 -> addresses 0000, 0002, 0004 on consecutive cycles; pc_add_out 0002, 0004, 0006; fetch_stall=0.
- Miss at pc=0x0010, imem_valid low 3 cycles then high with 16'hA5A5 -> fetch_stall=1 for 3 cycles, imem_addr held at 0010, then instr_out=A5A5, next addr 0012.
- redirect_en with redirect_pc=0x0100 during the 2nd miss cycle -> addr stays 0x0010 until valid; fill discarded (fetch_stall=1); next cycle addr=0x0100.
- Fetch 16'hF000 at pc=0x0020 -> next cycle halted=1, imem_req=0. Then redirect_en to 0x0040 -> halted=0, addr=0x0040.
- pc=0xFFFE with hit -> pc_add_out=0x0000, next addr 0x0000. stall_en+redirect_en same cycle -> pc=redirect_pc.
- rst_n low during MISS -> next cycle state RUN, addr=RESET_PC, redir_pend cleared.
